// File: rtl/kyber_pkg.sv
// Shared Kyber polynomial-RAM constants and the coefficient reader state encoding.
package kyber_pkg;

  localparam int COEF_W         = 12;
  localparam int COEFS_PER_WORD = 8;
  localparam int RAM_ADDR_W     = 10;
  localparam int WORD_W         = COEF_W * COEFS_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } rd_state_t;

endpackage

// File: rtl/ram_coef_reader.sv
// Streams a run of RAM words as one coefficient per handshake; first coef_valid two cycles after start.
// coef_ready low freezes all state and the presented coefficient; a one-word prefetch avoids bubbles.
module ram_coef_reader #(
  parameter int ADDR_W = kyber_pkg::RAM_ADDR_W,
  parameter int COEF_W = kyber_pkg::COEF_W,
  parameter int COEFS  = kyber_pkg::COEFS_PER_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           num_words,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         raddr,
  input  logic [COEF_W*COEFS-1:0]   rdata,
  output logic                      coef_valid,
  input  logic                      coef_ready,
  output logic [COEF_W-1:0]         coef_data,
  output logic                      coef_last
);

  import kyber_pkg::rd_state_t;
  import kyber_pkg::IDLE;
  import kyber_pkg::LOAD;
  import kyber_pkg::EMIT;
  import kyber_pkg::DONE;

  localparam int WORD_W = COEF_W * COEFS;
  localparam int LANE_W = $clog2(COEFS);
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(COEFS - 1);

  rd_state_t           state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W:0]     remaining, remaining_n;
  logic [LANE_W-1:0]   lane, lane_n;
  logic [WORD_W-1:0]   word_reg, word_n;

  logic emit;
  logic last_lane;
  logic handshake;

  assign emit      = (state == EMIT);
  assign last_lane = (lane == LANE_MAX);
  assign handshake = emit && coef_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      lane      <= '0;
      word_reg  <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      lane      <= lane_n;
      word_reg  <= word_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    lane_n      = lane;
    word_n      = word_reg;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            addr_n      = base_addr;
            remaining_n = num_words;
            state_n     = LOAD;
          end else begin
            state_n = DONE;
          end
        end
      end
      LOAD: begin
        word_n      = rdata;
        lane_n      = '0;
        addr_n      = addr + ADDR_W'(1);
        remaining_n = remaining - (ADDR_W + 1)'(1);
        state_n     = EMIT;
      end
      EMIT: begin
        if (handshake) begin
          if (!last_lane) begin
            lane_n = lane + LANE_W'(1);
          end else if (remaining != '0) begin
            // raddr already points at the next word, so it is captured on the same edge
            word_n      = rdata;
            lane_n      = '0;
            addr_n      = addr + ADDR_W'(1);
            remaining_n = remaining - (ADDR_W + 1)'(1);
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign raddr      = addr;
  assign coef_valid = emit;
  assign coef_last  = emit && last_lane && (remaining == '0);
  assign coef_data  = emit ? word_reg[lane*COEF_W +: COEF_W] : '0;

endmodule

// File: tb/tb_ram_coef_reader.sv
// Directed bench for ram_coef_reader with a combinational RAM model and a per-coefficient scoreboard.
module tb_ram_coef_reader;

  localparam int ADDR_W = 10;
  localparam int COEF_W = 12;
  localparam int COEFS  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [ADDR_W:0]         num_words;
  logic                    busy;
  logic                    done;
  logic [ADDR_W-1:0]       raddr;
  logic [COEF_W*COEFS-1:0] rdata;
  logic                    coef_valid;
  logic                    coef_ready;
  logic [COEF_W-1:0]       coef_data;
  logic                    coef_last;

  logic [COEF_W*COEFS-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  ram_coef_reader #(.ADDR_W(ADDR_W), .COEF_W(COEF_W), .COEFS(COEFS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .rdata      (rdata),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_last  (coef_last)
  );

  assign rdata = mem[raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word 5 holds 1..8 by hand; every other word follows a lane-distinct arithmetic pattern.
  function automatic logic [COEF_W-1:0] coef_of(input int w, input int l);
    if (w == 5) return COEF_W'(l + 1);
    return COEF_W'((w * 8 + l) * 37 + 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge of the cycle after start was sampled.
  task automatic do_start(input int base, input int n);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    num_words = (ADDR_W + 1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream(input int base, input int n, input bit rand_ready,
                        input int inject_at, output int cycles);
    int got;
    int cyc;
    bit fin;
    bit stalled;
    logic [COEF_W-1:0] held;
    got     = 0;
    cyc     = 0;
    fin     = 1'b0;
    stalled = 1'b0;
    held    = '0;
    check("load_busy", 32'(busy), 1);
    check("load_valid", 32'(coef_valid), 0);
    check("load_raddr", 32'(raddr), 32'(base % DEPTH));
    while (!fin && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == inject_at) begin
        start     = 1'b1;
        base_addr = ADDR_W'(100);
        num_words = (ADDR_W + 1)'(2);
      end
      coef_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        fin = 1'b1;
        check("done_valid", 32'(coef_valid), 0);
      end else begin
        if (stalled) begin
          check("stall_valid", 32'(coef_valid), 1);
          check("stall_data", 32'(coef_data), 32'(held));
        end
        if (coef_valid && coef_ready) begin
          check("coef", 32'(coef_data), 32'(coef_of((base + got / 8) % DEPTH, got % 8)));
          check("last", 32'(coef_last), 32'(got == 8 * n - 1));
          if (got % 8 == 0)
            check("prefetch_raddr", 32'(raddr), 32'((base + got / 8 + 1) % DEPTH));
          got++;
        end
        stalled = coef_valid && !coef_ready;
        held    = coef_data;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(fin), 1);
    check("coef_count", 32'(got), 32'(8 * n));
    @(negedge clk);
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    cycles = cyc;
  endtask

  initial begin
    int cyc;
    for (int w = 0; w < DEPTH; w++)
      for (int l = 0; l < COEFS; l++)
        mem[w][l*COEF_W +: COEF_W] = coef_of(w, l);

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    num_words  = '0;
    coef_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(coef_valid), 0);
    check("rst_last", 32'(coef_last), 0);
    check("rst_data", 32'(coef_data), 0);
    check("rst_raddr", 32'(raddr), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Single word at address 5: coefficients 1..8, done one cycle after the last.
    do_start(5, 1);
    stream(5, 1, 1'b0, -1, cyc);
    check("single_cycles", 32'(cyc), 9);

    // Four back-to-back words with no bubble.
    do_start(0, 4);
    stream(0, 4, 1'b0, -1, cyc);
    check("b2b_cycles", 32'(cyc), 33);

    // Random backpressure.
    do_start(0, 4);
    stream(0, 4, 1'b1, -1, cyc);
    do_start(10, 3);
    stream(10, 3, 1'b1, -1, cyc);

    // Address wrap.
    do_start(1022, 4);
    stream(1022, 4, 1'b0, -1, cyc);
    check("wrap_cycles", 32'(cyc), 33);

    // Zero length run.
    do_start(7, 0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 1);
    check("zero_valid", 32'(coef_valid), 0);
    @(negedge clk);
    check("zero_done_after", 32'(done), 0);
    check("zero_busy_after", 32'(busy), 0);
    check("zero_valid_after", 32'(coef_valid), 0);

    // Start pulse during a busy run is ignored.
    do_start(200, 2);
    stream(200, 2, 1'b0, 5, cyc);
    check("ignored_start_cycles", 32'(cyc), 17);

    // Maximum run length wraps the whole RAM.
    do_start(3, 1024);
    stream(3, 1024, 1'b0, -1, cyc);
    check("full_cycles", 32'(cyc), 8193);

    // Reset while the eleventh coefficient of a three-word run is presented.
    do_start(20, 3);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      coef_ready = 1'b1;
      check("pre_rst_coef", 32'(coef_data), 32'(coef_of(20 + i / 8, i % 8)));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(coef_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_raddr", 32'(raddr), 0);
    check("abort_data", 32'(coef_data), 0);
    @(negedge clk);
    check("abort_no_done", 32'(done), 0);
    check("abort_idle", 32'(busy), 0);

    do_start(40, 1);
    stream(40, 1, 1'b0, -1, cyc);
    check("restart_cycles", 32'(cyc), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_coef_reader.md
# ram_coef_reader

Streaming read master for the 96x1024 polynomial RAM. On a start command it fetches a run of consecutive 96-bit words (eight 12-bit Kyber coefficients each) through one combinational read port. It then emits them one coefficient per handshake on a valid/ready stream to downstream arithmetic (NTT butterfly, compress, encode). A one-word prefetch keeps the stream at one coefficient per cycle when the sink never stalls.

## Interface

Parameters:
- ADDR_W, 10, RAM address width; depth 2**ADDR_W words.
- COEF_W, 12, coefficient width.
- COEFS, 8, coefficients per RAM word; word width = COEF_W*COEFS = 96.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  command strobe; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- num_words  in  ADDR_W+1  words to stream, 0..1024; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run ends.
- raddr  out  ADDR_W  RAM read address; driven from a register.
- rdata  in  COEF_W*COEFS  RAM read data; combinational function of raddr within the same cycle.
- coef_valid  out  1  coef_data holds a valid coefficient.
- coef_ready  in  1  sink accepts the coefficient.
- coef_data  out  COEF_W  current coefficient.
- coef_last  out  1  high with the final coefficient of the run.

## Operation

- States: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - start=1 with num_words≠0: latch addr=base_addr and remaining=num_words, then go to LOAD.
  - start=1 with num_words=0: go to DONE. No coefficients are emitted.
  - start=0: stay in IDLE.
- LOAD, one cycle:
  - raddr=addr.
  - At the edge, word_reg<=rdata, lane<=0, addr<=addr+1 (mod 2**ADDR_W), remaining<=remaining-1.
  - Next state is EMIT.
- EMIT:
  - coef_valid=1.
  - coef_data = word_reg[lane*COEF_W +: COEF_W]. Lane 0 is bits [11:0]; lane 7 is bits [95:84].
  - coef_last = (lane==COEFS-1) && (remaining==0).
- A handshake is coef_valid && coef_ready in EMIT. On a handshake:
  - lane<COEFS-1: lane<=lane+1.
  - lane==COEFS-1 and remaining≠0: prefetch. word_reg<=rdata (raddr already equals addr), lane<=0, addr<=addr+1, remaining<=remaining-1. Stay in EMIT with no bubble.
  - lane==COEFS-1 and remaining==0: go to DONE.
- Without a handshake, all state holds and coef_data/coef_last stay stable (AXI-style stability rule).
- DONE: done=1 for this one cycle, then go to IDLE. The next start can be accepted in the cycle after DONE.
- start is ignored while busy.
- Address wraps modulo 1024; base_addr=1020 with num_words=8 reads words 1020..1023, then 0..3.
- RAM writes to the word being read in the same cycle as its capture edge are not seen; the pre-write content is captured.

## Timing

- Reset values:
  - Outputs: busy=0, done=0, coef_valid=0, coef_last=0, coef_data=0, raddr=0.
  - Internal state: IDLE, lane=0, remaining=0, word_reg=0.
- rst has priority over all other inputs. Asserting it mid-run aborts the run with no done pulse, and the next cycle shows the reset values above.
- Latency: start accepted in cycle t gives LOAD in t+1 and the first coef_valid in t+2.
- Throughput: with coef_ready held high, a run of N words emits 8N coefficients in cycles t+2..t+8N+1, done pulses in t+8N+2, and busy falls after that cycle.
- num_words=0: done pulses in t+1; coef_valid never rises.
- raddr changes only on clock edges.

## Structure

- Shared package kyber_pkg holds:
  - COEF_W=12, COEFS_PER_WORD=8, RAM_ADDR_W=10, WORD_W=96.
  - State enum rd_state_t {IDLE, LOAD, EMIT, DONE}.
- Single flat module with no sub-modules; the lane select is a simple indexed part-select.

## Test plan

- Single word: preload word 5 with coefficients 0x001..0x008 in lanes 0..7. start, base=5, n=1, ready=1 → coef_data 0x001..0x008 in cycles t+2..t+9, coef_last only on 0x008, done at t+10.
- Back-to-back words: n=4 from base 0, ready=1 → 32 consecutive valid cycles with no bubble; raddr sequence 0,1,2,3,4.
- Backpressure: toggle coef_ready randomly at 50% → coefficient sequence identical to the ready=1 run; coef_data stable whenever valid=1 and ready=0.
- Wrap: base=1022, n=4 → words read in order 1022, 1023, 0, 1.
- Zero length and ignored start: n=0 → done at t+1 with no valid. During a busy run, pulse start with base=100 → the run is unaffected.
- Reset mid-run: assert rst at coefficient 11 of a 3-word run → next cycle busy=0, valid=0, no done. A new start then runs normally from its own base.
